// File: rtl/dm_io_responder_pkg.sv
// Shared register map, bit positions and CTRL field layout for dm_io_responder.
package dm_io_pkg;

  localparam logic [4:0] IDX_CYCLE  = 5'd0;
  localparam logic [4:0] IDX_CTRL   = 5'd1;
  localparam logic [4:0] IDX_CMP    = 5'd2;
  localparam logic [4:0] IDX_TCNT   = 5'd3;
  localparam logic [4:0] IDX_STATUS = 5'd4;
  localparam logic [4:0] IDX_TXDATA = 5'd5;

  localparam int unsigned CTRL_TEN  = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IEN  = 2;

  localparam int unsigned ST_EXP     = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  typedef struct packed {
    logic ien;
    logic auto_rld;
    logic ten;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [2:0] w);
    ctrl_t c;
    c.ten      = w[CTRL_TEN];
    c.auto_rld = w[CTRL_AUTO];
    c.ien      = w[CTRL_IEN];
    return c;
  endfunction

endpackage

// File: rtl/dm_io_responder_sync_fifo.sv
// Synchronous FIFO with registered storage; a push while full is dropped and flagged.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_pulse_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign count_o     = cnt_q;
  assign head_o      = mem_q[rptr_q];
  // Fullness is judged on the pre-edge count, so a simultaneous pop cannot rescue a push.
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign ovf_pulse_o = push_i & full_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dm_io_responder.sv
// DM-port I/O responder: cycle counter, compare timer, TX FIFO.
// Optional registered interrupt output enabled by defining DM_IO_IRQ_EN.
module dm_io_responder
  import dm_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                ena,
  input  logic                worr,
  input  logic [4:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [TX_WIDTH-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
`ifdef DM_IO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0] cycle_q, cycle_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        exp_q, exp_d;
  logic        ovf_q, ovf_d;
  logic        exp_set;

  logic we, re;
  logic wr_ctrl, wr_cmp, wr_status, wr_tx;

  logic             fifo_full, fifo_empty, fifo_ovf;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      status_w;

  assign we        = sel & ena & worr;
  assign re        = sel & ena & ~worr;
  assign wr_ctrl   = we & (addr == IDX_CTRL);
  assign wr_cmp    = we & (addr == IDX_CMP);
  assign wr_status = we & (addr == IDX_STATUS);
  assign wr_tx     = we & (addr == IDX_TXDATA);

  assign tx_valid = ~fifo_empty;

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(TX_WIDTH)
  ) u_txfifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (wr_tx),
    .push_data_i(wdata[TX_WIDTH-1:0]),
    .pop_i      (tx_valid & tx_ready),
    .head_o     (tx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt),
    .ovf_pulse_o(fifo_ovf)
  );

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    tcnt_d  = tcnt_q;
    exp_d   = exp_q;
    ovf_d   = ovf_q;
    exp_set = 1'b0;

    // A CTRL/CMP write restarts the count and suppresses the compare on that edge.
    if (wr_ctrl || wr_cmp) begin
      tcnt_d = '0;
      if (wr_ctrl) ctrl_d = ctrl_from_word(wdata[2:0]);
      if (wr_cmp)  cmp_d  = wdata;
    end else if (ctrl_q.ten) begin
      if (tcnt_q == cmp_q) begin
        exp_set = 1'b1;
        if (ctrl_q.auto_rld) tcnt_d = '0;
        else                 ctrl_d.ten = 1'b0;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end

    // Hardware sets take priority over same-cycle W1C clears.
    if (wr_status && wdata[ST_EXP]) exp_d = 1'b0;
    if (exp_set)                    exp_d = 1'b1;
    if (wr_status && wdata[ST_OVF]) ovf_d = 1'b0;
    if (fifo_ovf)                   ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      ctrl_q  <= '0;
      cmp_q   <= '0;
      tcnt_q  <= '0;
      exp_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      tcnt_q  <= tcnt_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status_w                   = '0;
    status_w[ST_EXP]           = exp_q;
    status_w[ST_FULL]          = fifo_full;
    status_w[ST_EMPTY]         = fifo_empty;
    status_w[ST_OVF]           = ovf_q;
    status_w[ST_CNT_LSB +: 8]  = 8'(fifo_cnt);
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      case (addr)
        IDX_CYCLE:  rdata = cycle_q;
        IDX_CTRL:   rdata = {29'd0, ctrl_q};
        IDX_CMP:    rdata = cmp_q;
        IDX_TCNT:   rdata = tcnt_q;
        IDX_STATUS: rdata = status_w;
        default:    rdata = '0;
      endcase
    end
  end

`ifdef DM_IO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = exp_q & ctrl_q.ien;
  assign irq   = irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
`endif

endmodule
